counter_scoreboard_chk: RTL

Parametrised self-checking scoreboard for the multi-mode up/down/load counter family. It runs a cycle-accurate reference model of the counter at WIDTH bits with a configurable large step. Each cycle it compares the DUT's registered outputs against the model and keeps mismatch statistics plus first-failure capture for the testbench. It sits beside the DUT in the verification environment, driven by the same stimulus as the DUT. It is simulation-only, and 4-state compares (X/Z) are permitted.

---
 rtl/counter_scoreboard_chk_if.sv | 37 +++
 rtl/counter_scoreboard_chk.sv | 125 ++++++++++++
 2 files changed

// File: rtl/counter_scoreboard_chk_if.sv
// Bundle of stimulus, DUT-observed and checker-result signals for the
// counter scoreboard. The stimulus side (bench) uses master; the checker uses slave.
interface counter_scoreboard_chk_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) ();
  logic             ENABLE;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] dut_q;
  logic             dut_rco;
  logic             dut_load;

  logic [WIDTH-1:0] exp_q;
  logic             exp_rco;
  logic             exp_load;
  logic             exp_valid;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_exp_q;
  logic [WIDTH-1:0] first_err_dut_q;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output ENABLE, MODO, D, dut_q, dut_rco, dut_load,
    input  exp_q, exp_rco, exp_load, exp_valid, mismatch, err_cnt, chk_cnt,
           first_err_valid, first_err_exp_q, first_err_dut_q, first_err_idx
  );

  modport slave (
    input  ENABLE, MODO, D, dut_q, dut_rco, dut_load,
    output exp_q, exp_rco, exp_load, exp_valid, mismatch, err_cnt, chk_cnt,
           first_err_valid, first_err_exp_q, first_err_dut_q, first_err_idx
  );
endinterface

// File: rtl/counter_scoreboard_chk.sv
// Cycle-accurate reference model of the up/down/load counter plus a compare
// stage with saturating statistics and first-failure capture.
module counter_scoreboard_chk #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_A = 3,
  parameter int unsigned CNT_W  = 8
) (
  input logic                     clk,
  input logic                     RESET,
  counter_scoreboard_chk_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam logic [WIDTH-1:0] Step   = WIDTH'(STEP_A);
  // exp_q at or above this value wraps when stepping by STEP_A
  localparam logic [WIDTH-1:0] RcoThr = WIDTH'((1 << WIDTH) - STEP_A);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e state_q;
  logic   mis;

  // 4-state inequality: X/Z on any DUT output bit counts as a mismatch
  assign mis = ({bus.dut_q, bus.dut_rco, bus.dut_load} !==
                {bus.exp_q, bus.exp_rco, bus.exp_load});

  // FSM and counter model; exp_valid is registered alongside the state
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q       <= StIdle;
      bus.exp_valid <= 1'b0;
      bus.exp_q     <= '0;
      bus.exp_rco   <= 1'b0;
      bus.exp_load  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (bus.ENABLE) begin
            state_q       <= StRun;
            bus.exp_valid <= 1'b1;
          end
        end
        StRun: begin
          if (!bus.ENABLE) begin
            state_q       <= StHold;
            bus.exp_valid <= 1'b0;
          end
        end
        default: begin
          state_q       <= StIdle;
          bus.exp_valid <= 1'b0;
        end
      endcase

      if (bus.ENABLE) begin
        if ($isunknown(bus.MODO)) begin
          bus.exp_q    <= '0;
          bus.exp_rco  <= 1'b0;
          bus.exp_load <= 1'b0;
        end else begin
          unique case (bus.MODO)
            2'b00: begin
              bus.exp_q    <= bus.exp_q + Step;
              bus.exp_rco  <= (bus.exp_q >= RcoThr);
              bus.exp_load <= 1'b0;
            end
            2'b01: begin
              bus.exp_q    <= bus.exp_q - 1'b1;
              bus.exp_rco  <= (bus.exp_q == '0);
              bus.exp_load <= 1'b0;
            end
            2'b10: begin
              bus.exp_q    <= bus.exp_q + 1'b1;
              bus.exp_rco  <= (bus.exp_q == '1);
              bus.exp_load <= 1'b0;
            end
            2'b11: begin
              bus.exp_q    <= bus.D;
              bus.exp_rco  <= 1'b0;
              bus.exp_load <= 1'b1;
            end
          endcase
        end
      end else begin
        // count value holds so counting resumes from it on re-enable
        bus.exp_rco  <= 1'b0;
        bus.exp_load <= 1'b0;
      end
    end
  end

  // Compare against pre-edge model outputs; statistics and first-error capture
  always_ff @(posedge clk) begin
    if (RESET) begin
      bus.mismatch        <= 1'b0;
      bus.err_cnt         <= '0;
      bus.chk_cnt         <= '0;
      bus.first_err_valid <= 1'b0;
      bus.first_err_exp_q <= '0;
      bus.first_err_dut_q <= '0;
      bus.first_err_idx   <= '0;
    end else begin
      bus.mismatch <= 1'b0;
      if (bus.exp_valid) begin
        bus.mismatch <= mis;
        if (bus.chk_cnt != CntMax) begin
          bus.chk_cnt <= bus.chk_cnt + CntOne;
        end
        if (mis) begin
          if (bus.err_cnt != CntMax) begin
            bus.err_cnt <= bus.err_cnt + CntOne;
          end
          if (!bus.first_err_valid) begin
            bus.first_err_valid <= 1'b1;
            bus.first_err_exp_q <= bus.exp_q;
            bus.first_err_dut_q <= bus.dut_q;
            bus.first_err_idx   <= bus.chk_cnt;
          end
        end
      end
    end
  end

endmodule
